alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 clk  in  1  single rising-edge clock for all state.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 op_valid  in  1  requester offers an operation.
REQ-004 op_ready  out  1  dispatcher can accept; transfer when op_valid & op_ready at posedge.
REQ-005 opcode  in  3  000 CMP, 001 ADD, 010 SUB, 011 DIV, 100 MUL, 101-111 illegal.
REQ-006 A, B  in  8 each  operands offered with opcode.
REQ-007 opA, opB  out  8 each  latched operands driven to all arithmetic units.
REQ-008 aCmp, aAdd, aSub, aDiv, aMul  out  1 each  unit activations, at most one high.
REQ-009 res_valid  out  1  one-cycle pulse, result register Y holds the accepted op's result.
REQ-010 err  out  1  one-cycle pulse, accepted op rejected (illegal opcode or DIV with B==0).
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states IDLE, EXEC, DONE; op_ready SHALL equal (state==IDLE).
REQ-013 IDLE: on accept, latch opcode/A/B; legal and not div-by-zero -> EXEC; otherwise -> DONE with error flag set.
REQ-014 opA/opB SHALL update only on accept and hold stable until the next accept.
REQ-015 Activation latency LAT: CMP 1, ADD 1, SUB 1, MUL 3, DIV 8 cycles.
REQ-016 EXEC: exactly one activation, one-hot by latched opcode, held high for exactly LAT consecutive cycles; -> DONE after the last.
REQ-017 Accept at edge k: activation high cycles k+1..k+LAT; res_valid high cycle k+LAT+1; op_ready high again cycle k+LAT+2.
REQ-018 DONE lasts exactly one cycle: res_valid=1 if no error flag, else err=1; never both; -> IDLE.
REQ-019 Rejected op: no activation ever asserted; err in cycle k+1; op_ready again in k+2.
REQ-020 op_valid while op_ready=0 SHALL be ignored; opcode/A/B changes outside accept have no effect.
REQ-021 Back-to-back: op_valid held high gives one accept per LAT+2 cycles, no lost or duplicated ops.
REQ-022 Latency counter 4-bit, loaded with LAT-1 on accept, decremented each EXEC cycle, exit at 0; no wrap.
REQ-023 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-024 rst=1 at a posedge: state IDLE, all activations 0, res_valid 0, err 0, busy 0, opA/opB 8'h00, counter 0.
REQ-025 op_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-026 rst during EXEC or DONE aborts: activations drop at that edge, no res_valid/err emitted for the aborted op.
REQ-027 rst has priority over a simultaneous accept; the offered op is not accepted.

Structure
REQ-028 Shared package alu_pkg: opcode constants, per-op LAT constants, FSM state enumeration, data width 8.
REQ-029 One sub-module lat_counter (load, decrement, zero flag); all else in alu_dispatch.

Verification
REQ-030 Reset, then ADD A=8'h05 B=8'h03 at edge 0 -> aAdd high cycle 1 only, res_valid cycle 2, op_ready cycle 3, opA=05 opB=03.
REQ-031 DIV A=8'h40 B=8'h04 -> aDiv high cycles 1-8, res_valid cycle 9, other activations 0 throughout.
REQ-032 opcode 3'b111, then DIV with B=8'h00 -> err pulse each, zero activation cycles, res_valid never high.
REQ-033 op_valid held high, sequence MUL, CMP, SUB -> accepts at edges 0, 5, 8; aMul 3 cycles, aCmp 1, aSub 1; three res_valid pulses.
REQ-034 rst asserted in cycle 4 of a DIV -> aDiv low from that edge, no res_valid, op_ready 1 cycle after rst release, next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatcher: opcodes, unit latencies,
// FSM states and small decode helpers.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int N_UNITS = 5;

  localparam logic [2:0] OP_CMP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [3:0] LAT_CMP = 4'd1;
  localparam logic [3:0] LAT_ADD = 4'd1;
  localparam logic [3:0] LAT_SUB = 4'd1;
  localparam logic [3:0] LAT_MUL = 4'd3;
  localparam logic [3:0] LAT_DIV = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MUL);
  endfunction

  // Activation cycles for a legal opcode; illegal opcodes never reach EXEC.
  function automatic logic [3:0] op_lat(input logic [2:0] op);
    case (op)
      OP_CMP:  return LAT_CMP;
      OP_ADD:  return LAT_ADD;
      OP_SUB:  return LAT_SUB;
      OP_DIV:  return LAT_DIV;
      OP_MUL:  return LAT_MUL;
      default: return 4'd1;
    endcase
  endfunction

  // Bit position of each unit's activation equals its opcode value.
  function automatic logic [N_UNITS-1:0] op_onehot(input logic [2:0] op);
    if (op_legal(op)) return N_UNITS'(1) << op;
    return '0;
  endfunction

endpackage

// File: rtl/alu_dispatch_lat_counter.sv
// Activation latency counter: load on accept, count down while executing,
// hold at zero (no wrap).
module lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst)                     cnt <= 4'd0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/alu_dispatch.sv
// ALU operation dispatcher: accepts one operation at a time, latches its
// operands, pulses the matching unit activation for that unit's latency,
// then reports completion (res_valid) or rejection (err) for one cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new operation (op_ready=1)
// EXEC  | one unit activation held high, latency counter running
// DONE  | single cycle: res_valid or err pulse, then back to IDLE
module alu_dispatch
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic              aCmp,
  output logic              aAdd,
  output logic              aSub,
  output logic              aDiv,
  output logic              aMul,
  output logic              res_valid,
  output logic              err,
  output logic              busy
);

  state_t             state;
  logic [N_UNITS-1:0] act;
  logic               op_ok;
  logic               accept;
  logic               cnt_zero;

  assign op_ok  = op_legal(opcode) && !((opcode == OP_DIV) && (B == '0));
  assign accept = (state == S_IDLE) && op_valid;

  lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && op_ok),
    .load_val (op_lat(opcode) - 4'd1),
    .dec      (state == S_EXEC),
    .zero     (cnt_zero)
  );

  // Dispatch FSM; all outputs except the state decodes are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      act       <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      opA       <= '0;
      opB       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            opA <= A;
            opB <= B;
            if (op_ok) begin
              act   <= op_onehot(opcode);
              state <= S_EXEC;
            end else begin
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          if (cnt_zero) begin
            act       <= '0;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          res_valid <= 1'b0;
          err       <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          act       <= '0;
          res_valid <= 1'b0;
          err       <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is masked by rst so nothing looks acceptable while reset is held.
  assign op_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);

  assign aCmp = act[0];
  assign aAdd = act[1];
  assign aSub = act[2];
  assign aDiv = act[3];
  assign aMul = act[4];

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized scoreboard bench for alu_dispatch.
module tb_alu_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] opcode = 3'd0;
  logic [7:0] A = 8'h00, B = 8'h00;
  logic [7:0] opA, opB;
  logic       aCmp, aAdd, aSub, aDiv, aMul;
  logic       res_valid, err, busy;

  alu_dispatch dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .A(A), .B(B), .opA(opA), .opB(opB),
    .aCmp(aCmp), .aAdd(aAdd), .aSub(aSub), .aDiv(aDiv), .aMul(aMul),
    .res_valid(res_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [2:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    int         k;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic rst_q   = 1'b1;

  // Reference latencies indexed by opcode: CMP ADD SUB DIV MUL.
  int lat_tbl[5] = '{1, 1, 1, 8, 3};

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.opc    = opc;
    e.a      = a;
    e.b      = b;
    e.is_err = (opc > 3'd4) || (opc == 3'd3 && b == 8'h00);
    e.lat    = e.is_err ? 0 : lat_tbl[opc];
    e.k      = 0;
    return e;
  endfunction

  // Offer one operation; garbage is driven while the DUT is not ready.
  task automatic issue(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b,
                       input bit hold, output int k);
    exp_t e;
    bit   done = 0;
    k = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (op_ready) begin
        op_valid = 1'b1; opcode = opc; A = a; B = b;
        e   = model(opc, a, b);
        e.k = cyc + 1;
        k   = e.k;
        sb.push_back(e);
        @(posedge clk); #1;
        opcode = 3'($urandom); A = 8'($urandom); B = 8'($urandom);
        op_valid = hold;
        done = 1;
      end else begin
        op_valid = hold ? 1'b1 : 1'($urandom);
        opcode = 3'($urandom); A = 8'($urandom); B = 8'($urandom);
      end
    end
    if (!done) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    op_valid = 1'b1; opcode = 3'd1; A = 8'hAA; B = 8'h55;
    repeat (n) @(negedge clk);
    #1 chk("ready_in_reset", op_ready, 1'b0);
    rst = 1'b0;
    op_valid = 1'b0;
    #1 chk("ready_after_reset", op_ready, 1'b1);
  endtask

  // Monitor: attribute activation cycles to the oldest outstanding op and
  // score it when the DUT reports res_valid or err.
  int act_cnt = 0;
  bit act_bad = 0;
  int ready_chk_cyc = -1;
  initial begin
    logic [4:0] acts;
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      acts = {aMul, aDiv, aSub, aAdd, aCmp};
      if (rst_q) begin
        chk("rst_acts", acts, 5'd0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_opA", opA, 8'h00);
        chk("rst_opB", opB, 8'h00);
        sb.delete();
        act_cnt = 0; act_bad = 0; ready_chk_cyc = -1;
      end else begin
        if (acts != 5'd0) begin
          if (sb.size() == 0 || $countones(acts) != 1) act_bad = 1;
          else if (acts != (5'd1 << sb[0].opc) || sb[0].is_err ||
                   cyc - sb[0].k < 0 || cyc - sb[0].k >= sb[0].lat) act_bad = 1;
          else act_cnt++;
        end
        if (ready_chk_cyc == cyc) begin
          chk("ready_after_done", op_ready, 1'b1);
          ready_chk_cyc = -1;
        end
        if (res_valid || err) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", {res_valid, err}, 2'b00);
          end else begin
            e = sb.pop_front();
            chk($sformatf("kind_op%0d", e.opc), {res_valid, err}, e.is_err ? 2'b01 : 2'b10);
            chk($sformatf("latency_op%0d", e.opc), cyc - e.k, e.lat);
            chk($sformatf("act_cycles_op%0d", e.opc), act_cnt, e.lat);
            chk($sformatf("act_wrong_op%0d", e.opc), act_bad, 1'b0);
            chk("opA", opA, e.a);
            chk("opB", opB, e.b);
            chk("busy_done", busy, 1'b1);
            ready_chk_cyc = cyc + 1;
          end
          act_cnt = 0; act_bad = 0;
        end
      end
    end
  end

  initial begin
    int k0, k1, k2;
    logic [2:0] opc;
    logic [7:0] b;
    do_reset(3);

    // Single ADD, single DIV, two rejected ops.
    issue(3'b001, 8'h05, 8'h03, 0, k0);
    issue(3'b011, 8'h40, 8'h04, 0, k0);
    issue(3'b111, 8'h12, 8'h34, 0, k0);
    issue(3'b011, 8'h40, 8'h00, 0, k0);

    // Back-to-back with op_valid held: MUL, CMP, SUB.
    issue(3'b100, 8'h07, 8'h09, 1, k0);
    issue(3'b000, 8'h11, 8'h22, 1, k1);
    issue(3'b010, 8'h33, 8'h44, 0, k2);
    op_valid = 1'b0;
    chk("b2b_gap_mul", k1 - k0, 5);
    chk("b2b_gap_cmp", k2 - k1, 3);

    // Reset in the middle of a DIV, then a normal ADD.
    issue(3'b011, 8'h81, 8'h03, 0, k0);
    repeat (2) @(negedge clk);
    do_reset(2);
    issue(3'b001, 8'hF0, 8'h0F, 0, k0);

    // Randomized ops, including illegal opcodes and zero divisors.
    for (int i = 0; i < 60; i++) begin
      opc = 3'($urandom_range(0, 7));
      b   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      issue(opc, 8'($urandom), b, 1'($urandom), k0);
    end
    @(posedge clk); #1 op_valid = 1'b0;

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
